i2c_if: RTL and testbench
=========================

I2C_IF -- requirements
Module: i2c_if

Interface
REQ-001 Parameter I2C_ADDR_WIDTH, default 7: slave address width in bits.
REQ-002 Parameter I2C_DATA_WIDTH, default 8: data byte width in bits.
REQ-003 Parameter I2C_DEVICE_ADDR, default 8'h22: the slave's own 7-bit address, taken from the low I2C_ADDR_WIDTH bits.
REQ-004 clk_i  input  1: the single system clock; all logic on its rising edge.
REQ-005 rst_i  input  1: synchronous, active-high reset.
REQ-006 scl  inout  1: I2C clock; the block only samples it and never drives it (no clock stretching).
REQ-007 sda  inout  1: I2C data, open-drain; the block drives 1'b0 or releases to 'z, never drives 1.
REQ-008 rd_data  input  I2C_DATA_WIDTH: byte to return on a read; latched on the rd_req cycle.
REQ-009 rd_req  output  1: one-cycle pulse requesting the next read byte.
REQ-010 byte_valid  output  1: one-cycle pulse when a write data byte has been received.
REQ-011 byte_data  output  I2C_DATA_WIDTH: the received byte, held until the next byte_valid.
REQ-012 xfer_done  output  1: one-cycle pulse at STOP or repeated START that ends an addressed transfer.
REQ-013 xfer_addr, xfer_op, xfer_count  output  I2C_ADDR_WIDTH/1/8: address, op (0 = write, 1 = read) and byte count of the finished transfer, held until the next xfer_done.

Function
REQ-014 scl and sda shall each pass through a 2-flop synchronizer; all edge detection uses the synchronized values.
REQ-015 START condition: synchronized sda falls while scl is high. STOP condition: sda rises while scl is high. Both are recognized in every state.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-017 START from any state -> ADDR with bit counter cleared; if a transfer was addressed, xfer_done pulses first (repeated-START case).
REQ-018 ADDR: shift in 7 address bits plus the R/W bit, MSB first, on scl rising edges.
REQ-019 Address match -> ADDR_ACK: drive sda low from the next scl falling edge to the following scl falling edge.
REQ-020 Address mismatch -> IGNORE with sda released; IGNORE persists until START or STOP.
REQ-021 After the ACK, R/W = 0 -> WR_DATA. R/W = 1 -> pulse rd_req, latch rd_data, and go to RD_DATA.
REQ-022 WR_DATA: shift in 8 bits on scl rising edges. On the 8th bit: pulse byte_valid, increment xfer_count, go to WR_ACK. WR_ACK drives the ACK as in REQ-019, then returns to WR_DATA.
REQ-023 RD_DATA: on each scl falling edge, drive sda low for a 0 bit and release it for a 1 bit, MSB first. After the 8th bit, release sda on the next falling edge and go to RD_ACK.
REQ-024 RD_ACK: sample sda on the scl rising edge.
  - Low (ACK): increment xfer_count, pulse rd_req, latch the next byte, go to RD_DATA.
  - High (NACK): increment xfer_count, go to IGNORE.
REQ-025 STOP in any state: release sda; pulse xfer_done if a transfer was addressed; go to IDLE.
REQ-026 Simultaneous START/STOP detection and a data edge: the START/STOP takes priority.
REQ-027 xfer_count saturates at 255.

Reset
REQ-028 On rst_i: state IDLE, sda released, synchronizers set to 1, all pulse outputs 0, byte_data/xfer_addr/xfer_op/xfer_count 0. A reset mid-transfer releases sda in the same cycle.

Structure
REQ-029 A shared package holds i2c_op_t (WRITE = 0, READ = 1) and the state enum.
REQ-030 Sub-module i2c_sync_edge: synchronizer plus rise/fall and START/STOP detection. The FSM stays in i2c_if.

Verification
REQ-031 Master sends START, 0x44, 0x78, STOP -> both bytes ACKed; byte_valid pulses once with 0x78; xfer_done with addr 0x22, op 0, count 1.
REQ-032 Master sends START, 0x46 (address 0x23) -> 9th-bit sda stays high (NACK); no byte_valid or xfer_done at STOP.
REQ-033 START, 0x45, rd_data 0xA5, master NACKs -> sda carries 1010_0101; sda released; xfer_done with op 1, count 1.
REQ-034 START, 0x44, 0x11, repeated START, 0x45, read, NACK, STOP -> two xfer_done pulses: (0x22, 0, 1) then (0x22, 1, 1).
REQ-035 Assert rst_i while sda is held low during an ACK -> sda is 'z on the next clock and state is IDLE.
REQ-036 Master sends START, 0x44, 0x78, 0x9C, STOP -> byte_valid pulses twice (0x78, then 0x9C); xfer_count 2.

Source files
------------

// File: rtl/i2c_if_pkg.sv
// Shared types for the I2C slave interface: bus op encoding,
// FSM state encoding and a saturating byte-counter helper.
package i2c_if_pkg;

   typedef enum logic {
      I2C_WRITE = 1'b0,
      I2C_READ  = 1'b1
   } i2c_op_t;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_DATA  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_DATA  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } i2c_state_t;

   localparam logic [7:0] CNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizers for scl/sda plus edge, START and STOP
// detection, all derived from the synchronized copies.
module i2c_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_o,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic scl_meta_q, scl_meta_d;
   logic scl_sync_q, scl_sync_d;
   logic scl_prev_q, scl_prev_d;
   logic sda_meta_q, sda_meta_d;
   logic sda_sync_q, sda_sync_d;
   logic sda_prev_q, sda_prev_d;

   always_comb begin
      scl_meta_d = scl_i;
      scl_sync_d = scl_meta_q;
      scl_prev_d = scl_sync_q;
      sda_meta_d = sda_i;
      sda_sync_d = sda_meta_q;
      sda_prev_d = sda_sync_q;
   end

   // Idle bus level is high, so reset everything to 1 to avoid phantom edges
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_meta_q <= scl_meta_d;
         scl_sync_q <= scl_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_meta_q <= sda_meta_d;
         sda_sync_q <= sda_sync_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign scl_o      = scl_sync_q;
   assign sda_o      = sda_sync_q;
   assign scl_rise_o = scl_sync_q & ~scl_prev_q;
   assign scl_fall_o = ~scl_sync_q & scl_prev_q;
   assign start_o    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
   assign stop_o     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/i2c_if.sv
// I2C slave front end: address match, write-byte receive and
// read-byte transmit with per-transfer summary reporting.
module i2c_if
   import i2c_if_pkg::*;
#(
   parameter int         I2C_ADDR_WIDTH  = 7,
   parameter int         I2C_DATA_WIDTH  = 8,
   parameter logic [7:0] I2C_DEVICE_ADDR = 8'h22
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   inout  wire                       scl,
   inout  wire                       sda,
   input  logic [I2C_DATA_WIDTH-1:0] rd_data,
   output logic                      rd_req,
   output logic                      byte_valid,
   output logic [I2C_DATA_WIDTH-1:0] byte_data,
   output logic                      xfer_done,
   output logic [I2C_ADDR_WIDTH-1:0] xfer_addr,
   output logic                      xfer_op,
   output logic [7:0]                xfer_count
);

   localparam int AW = I2C_ADDR_WIDTH;
   localparam int DW = I2C_DATA_WIDTH;
   localparam int CW = $clog2(DW + 1);
   localparam logic [AW-1:0] OWN_ADDR = I2C_DEVICE_ADDR[AW-1:0];

   logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

   i2c_sync_edge u_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .scl_i      (scl),
      .sda_i      (sda),
      .scl_o      (scl_s),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_c),
      .stop_o     (stop_c)
   );

   i2c_state_t    state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [DW-1:0] tx_q, tx_d;
   logic          sda_oe_q, sda_oe_d;
   logic          ack_on_q, ack_on_d;
   logic          addressed_q, addressed_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   i2c_op_t       cur_op_q, cur_op_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          rd_req_q, rd_req_d;
   logic          byte_valid_q, byte_valid_d;
   logic [DW-1:0] byte_data_q, byte_data_d;
   logic          xfer_done_q, xfer_done_d;
   logic [AW-1:0] xfer_addr_q, xfer_addr_d;
   logic          xfer_op_q, xfer_op_d;
   logic [7:0]    xfer_count_q, xfer_count_d;
   logic [DW-1:0] rx_bits;

   assign rx_bits = {shift_q[DW-2:0], sda_s};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      tx_d         = tx_q;
      sda_oe_d     = sda_oe_q;
      ack_on_d     = ack_on_q;
      addressed_d  = addressed_q;
      cur_addr_d   = cur_addr_q;
      cur_op_d     = cur_op_q;
      cnt_d        = cnt_q;
      rd_req_d     = 1'b0;
      byte_valid_d = 1'b0;
      byte_data_d  = byte_data_q;
      xfer_done_d  = 1'b0;
      xfer_addr_d  = xfer_addr_q;
      xfer_op_d    = xfer_op_q;
      xfer_count_d = xfer_count_q;

      if (start_c || stop_c) begin
         if (addressed_q) begin
            xfer_done_d  = 1'b1;
            xfer_addr_d  = cur_addr_q;
            xfer_op_d    = cur_op_q;
            xfer_count_d = cnt_q;
         end
         addressed_d = 1'b0;
         sda_oe_d    = 1'b0;
         ack_on_d    = 1'b0;
         bit_cnt_d   = '0;
         state_d     = start_c ? ST_ADDR : ST_IDLE;
      end else begin
         unique case (state_q)
            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = rx_bits;
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CW'(AW)) begin
                     bit_cnt_d = '0;
                     if (rx_bits[AW:1] == OWN_ADDR) begin
                        state_d     = ST_ADDR_ACK;
                        addressed_d = 1'b1;
                        cur_addr_d  = rx_bits[AW:1];
                        cur_op_d    = i2c_op_t'(rx_bits[0]);
                        cnt_d       = 8'd0;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            // First falling edge starts the ACK, the next one ends it
            ST_ADDR_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!ack_on_q) begin
                     sda_oe_d = 1'b1;
                     ack_on_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     ack_on_d  = 1'b0;
                     bit_cnt_d = '0;
                     if (state_q == ST_ADDR_ACK && cur_op_q == I2C_READ) begin
                        rd_req_d = 1'b1;
                        state_d  = ST_RD_DATA;
                     end else begin
                        state_d = ST_WR_DATA;
                     end
                  end
               end
            end
            ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = rx_bits;
                  if (bit_cnt_q == CW'(DW - 1)) begin
                     byte_valid_d = 1'b1;
                     byte_data_d  = rx_bits;
                     cnt_d        = sat_inc(cnt_q);
                     bit_cnt_d    = '0;
                     state_d      = ST_WR_ACK;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            // MSB goes out now if scl is already low, else on the next fall
            ST_RD_DATA: begin
               if (rd_req_q) begin
                  tx_d      = rd_data;
                  bit_cnt_d = '0;
                  if (!scl_s) begin
                     sda_oe_d  = ~rd_data[DW-1];
                     tx_d      = {rd_data[DW-2:0], 1'b0};
                     bit_cnt_d = CW'(1);
                  end
               end else if (scl_fall) begin
                  if (bit_cnt_q == CW'(DW)) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = ST_RD_ACK;
                  end else begin
                     sda_oe_d  = ~tx_q[DW-1];
                     tx_d      = {tx_q[DW-2:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 1'b1;
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  cnt_d = sat_inc(cnt_q);
                  if (!sda_s) begin
                     rd_req_d  = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = ST_RD_DATA;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         tx_q         <= '0;
         sda_oe_q     <= 1'b0;
         ack_on_q     <= 1'b0;
         addressed_q  <= 1'b0;
         cur_addr_q   <= '0;
         cur_op_q     <= I2C_WRITE;
         cnt_q        <= 8'd0;
         rd_req_q     <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= '0;
         xfer_done_q  <= 1'b0;
         xfer_addr_q  <= '0;
         xfer_op_q    <= 1'b0;
         xfer_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tx_q         <= tx_d;
         sda_oe_q     <= sda_oe_d;
         ack_on_q     <= ack_on_d;
         addressed_q  <= addressed_d;
         cur_addr_q   <= cur_addr_d;
         cur_op_q     <= cur_op_d;
         cnt_q        <= cnt_d;
         rd_req_q     <= rd_req_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         xfer_done_q  <= xfer_done_d;
         xfer_addr_q  <= xfer_addr_d;
         xfer_op_q    <= xfer_op_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   // Reset releases the bus immediately rather than one edge later
   assign sda = (sda_oe_q && !rst_i) ? 1'b0 : 1'bz;

   assign rd_req     = rd_req_q;
   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign xfer_done  = xfer_done_q;
   assign xfer_addr  = xfer_addr_q;
   assign xfer_op    = xfer_op_q;
   assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_i2c_if.sv
// Directed bench for i2c_if: a bit-banged master on a pulled-up
// open-drain bus, with pulse logging and hand-computed expectations.
module tb_i2c_if;
   import i2c_if_pkg::*;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_low = 1'b0;
   logic [7:0] rd_data = 8'h00;
   logic       rd_req, byte_valid, xfer_done, xfer_op;
   logic [7:0] byte_data, xfer_count;
   logic [6:0] xfer_addr;
   wire        scl_w;
   wire        sda_w;

   int n_tests = 0;
   int n_fail  = 0;

   assign scl_w = m_scl;
   assign sda_w = m_low ? 1'b0 : 1'bz;
   pullup (sda_w);

   always #5 clk = ~clk;

   i2c_if dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .scl        (scl_w),
      .sda        (sda_w),
      .rd_data    (rd_data),
      .rd_req     (rd_req),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .xfer_done  (xfer_done),
      .xfer_addr  (xfer_addr),
      .xfer_op    (xfer_op),
      .xfer_count (xfer_count)
   );

   logic [7:0]  bv_log [16];
   logic [15:0] dn_log [16];
   int bv_n = 0;
   int dn_n = 0;
   int rq_n = 0;

   always @(negedge clk) begin
      if (byte_valid) begin
         bv_log[bv_n & 15] <= byte_data;
         bv_n <= bv_n + 1;
      end
      if (xfer_done) begin
         dn_log[dn_n & 15] <= {xfer_addr, xfer_op, xfer_count};
         dn_n <= dn_n + 1;
      end
      if (rd_req) rq_n <= rq_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      m_low = 1'b0;
      hold(Q);
      m_scl = 1'b1;
      hold(Q);
      m_low = 1'b1;
      hold(Q);
      m_scl = 1'b0;
      hold(2);
   endtask

   task automatic bus_stop();
      m_low = 1'b1;
      hold(Q);
      m_scl = 1'b1;
      hold(Q);
      m_low = 1'b0;
      hold(Q);
   endtask

   task automatic clk_bit(input logic drive_low, output logic seen);
      m_low = drive_low;
      hold(Q);
      m_scl = 1'b1;
      hold(Q);
      seen = sda_w;
      m_scl = 1'b0;
      hold(2);
   endtask

   task automatic tx_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
      clk_bit(1'b0, ack);
   endtask

   task automatic rx_byte(input logic give_ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b0, s);
         b[i] = s;
      end
      clk_bit(give_ack, s);
      m_low = 1'b0;
   endtask

   logic       ack;
   logic [7:0] rb;
   int         bv0, dn0, rq0;

   initial begin
      hold(4);
      rst = 1'b0;
      hold(2);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_xfer_done", xfer_done, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_byte_data", byte_data, 0);
      check("rst_xfer_count", xfer_count, 0);
      check("rst_xfer_addr", xfer_addr, 0);
      check("rst_sda", sda_w, 1);

      // single write byte
      bv0 = bv_n; dn0 = dn_n;
      bus_start();
      tx_byte(8'h44, ack);
      check("w1_addr_ack", ack, 0);
      tx_byte(8'h78, ack);
      check("w1_data_ack", ack, 0);
      bus_stop();
      check("w1_bv_n", bv_n - bv0, 1);
      check("w1_bv_data", bv_log[bv0 & 15], 8'h78);
      check("w1_done_n", dn_n - dn0, 1);
      check("w1_done", dn_log[dn0 & 15], {7'h22, 1'b0, 8'd1});
      check("w1_byte_data_held", byte_data, 8'h78);

      // foreign address
      bv0 = bv_n; dn0 = dn_n;
      bus_start();
      tx_byte(8'h46, ack);
      check("nm_nack", ack, 1);
      bus_stop();
      check("nm_bv_n", bv_n - bv0, 0);
      check("nm_done_n", dn_n - dn0, 0);

      // single read byte, master NACK
      dn0 = dn_n; rq0 = rq_n;
      rd_data = 8'hA5;
      bus_start();
      tx_byte(8'h45, ack);
      check("r1_addr_ack", ack, 0);
      rx_byte(1'b0, rb);
      check("r1_data", rb, 8'hA5);
      hold(4);
      check("r1_sda_released", sda_w, 1);
      check("r1_rd_req_n", rq_n - rq0, 1);
      bus_stop();
      check("r1_done_n", dn_n - dn0, 1);
      check("r1_done", dn_log[dn0 & 15], {7'h22, 1'b1, 8'd1});

      // write, repeated START, read
      dn0 = dn_n;
      rd_data = 8'h3C;
      bus_start();
      tx_byte(8'h44, ack);
      tx_byte(8'h11, ack);
      check("rs_w_ack", ack, 0);
      bus_start();
      check("rs_done_first_n", dn_n - dn0, 1);
      tx_byte(8'h45, ack);
      check("rs_r_ack", ack, 0);
      rx_byte(1'b0, rb);
      check("rs_r_data", rb, 8'h3C);
      bus_stop();
      check("rs_done_n", dn_n - dn0, 2);
      check("rs_done0", dn_log[dn0 & 15], {7'h22, 1'b0, 8'd1});
      check("rs_done1", dn_log[(dn0 + 1) & 15], {7'h22, 1'b1, 8'd1});

      // two write bytes
      bv0 = bv_n; dn0 = dn_n;
      bus_start();
      tx_byte(8'h44, ack);
      tx_byte(8'h78, ack);
      tx_byte(8'h9C, ack);
      check("w2_ack2", ack, 0);
      bus_stop();
      check("w2_bv_n", bv_n - bv0, 2);
      check("w2_bv0", bv_log[bv0 & 15], 8'h78);
      check("w2_bv1", bv_log[(bv0 + 1) & 15], 8'h9C);
      check("w2_count", xfer_count, 8'd2);
      check("w2_done", dn_log[dn0 & 15], {7'h22, 1'b0, 8'd2});

      // reset while the slave holds the ACK
      dn0 = dn_n;
      bus_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] a;
         a = 8'h44;
         clk_bit(~a[i], ack);
      end
      m_low = 1'b0;
      hold(Q);
      m_scl = 1'b1;
      hold(Q / 2);
      check("rs_ack_driven", sda_w, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_sda", sda_w, 1);
      check("rst_mid_state", dut.state_q, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;
      hold(Q);
      m_scl = 1'b0;
      hold(2);
      bus_stop();
      check("rst_mid_done_n", dn_n - dn0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
